// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot check sequencer.
// Holds the FSM state encoding, sysid word addresses and latency counter width.
package sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CMP   = 2'd3
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int   LAT_W         = 3;

    function automatic logic word_match(input logic [31:0] observed, input logic [31:0] expected);
        return (observed == expected);
    endfunction

endpackage

// File: rtl/sysid_lat_counter.sv
// Read-latency counter: clear has priority over count.
// The terminal flag is high when the count equals LATENCY.
module sysid_lat_counter
    import sysid_pkg::*;
#(
    parameter int unsigned LATENCY = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [LAT_W-1:0] TERM_VAL = LATENCY[LAT_W-1:0];

    logic [LAT_W-1:0] cnt_r;

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {LAT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {LAT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign term = (cnt_r == TERM_VAL);

endmodule

// File: rtl/sysid_check_seq.sv
// Boot-time sysid reader/checker. It owns the sysid slave while a check runs,
// then hands the slave to the host master as a latency-aware pass-through.
module sysid_check_seq
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1621684465,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        host_address,
    input  logic        host_read,
    output logic [31:0] host_readdata,
    output logic        host_waitrequest,
    output logic        sid_address,
    input  logic [31:0] sid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic AUTO_INIT = (AUTO_START != 0) ? 1'b1 : 1'b0;

    sysid_state_e state_r, state_next_s;
    logic         auto_pend_r;
    logic         busy_r, done_r, id_match_r, ts_match_r;
    logic [31:0]  id_value_r, ts_value_r;
    logic         go_s, seq_active_s, host_hold_s;
    logic         seq_clr_s, seq_en_s, seq_term_s;
    logic         host_clr_s, host_term_s;

    assign go_s         = start | auto_pend_r;
    assign seq_active_s = (state_r != IDLE);
    // The go cycle already belongs to the sequencer so a simultaneous host read cannot complete.
    assign host_hold_s  = seq_active_s | ((state_r == IDLE) & go_s);

    assign seq_en_s  = (state_r == RD_ID) | (state_r == RD_TS);
    assign seq_clr_s = ~seq_en_s | seq_term_s;
    assign host_clr_s = host_hold_s | ~host_read | host_term_s;

    sysid_lat_counter #(.LATENCY(READ_LATENCY)) u_seq_lat (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (seq_clr_s),
        .en      (seq_en_s),
        .term    (seq_term_s)
    );

    sysid_lat_counter #(.LATENCY(READ_LATENCY)) u_host_lat (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (host_clr_s),
        .en      (host_read),
        .term    (host_term_s)
    );

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (go_s) state_next_s = RD_ID; else state_next_s = IDLE;
            RD_ID:   if (seq_term_s) state_next_s = RD_TS; else state_next_s = RD_ID;
            RD_TS:   if (seq_term_s) state_next_s = CMP; else state_next_s = RD_TS;
            CMP:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Slave address mux and host stall.
    always_comb begin
        sid_address      = host_address;
        host_waitrequest = 1'b0;
        case (state_r)
            RD_ID:   sid_address = SYSID_ADDR_ID;
            RD_TS:   sid_address = SYSID_ADDR_TS;
            CMP:     sid_address = SYSID_ADDR_TS;
            IDLE:    sid_address = host_address;
            default: sid_address = host_address;
        endcase
        if (host_hold_s) begin
            host_waitrequest = host_read;
        end else begin
            host_waitrequest = host_read & ~host_term_s;
        end
    end

    // Sequencer state, captured words and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            auto_pend_r <= AUTO_INIT;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            id_match_r  <= 1'b0;
            ts_match_r  <= 1'b0;
            id_value_r  <= 32'd0;
            ts_value_r  <= 32'd0;
        end else begin
            state_r     <= state_next_s;
            auto_pend_r <= 1'b0;
            busy_r      <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        done_r     <= 1'b0;
                        id_match_r <= 1'b0;
                        ts_match_r <= 1'b0;
                    end
                end
                RD_ID: begin
                    if (seq_term_s) id_value_r <= sid_readdata;
                end
                RD_TS: begin
                    if (seq_term_s) ts_value_r <= sid_readdata;
                end
                CMP: begin
                    id_match_r <= word_match(id_value_r, EXPECTED_ID);
                    ts_match_r <= word_match(ts_value_r, EXPECTED_TS);
                    done_r     <= 1'b1;
                end
                default: begin
                    done_r <= done_r;
                end
            endcase
        end
    end

    assign host_readdata = sid_readdata;
    assign busy          = busy_r;
    assign done          = done_r;
    assign id_match      = id_match_r;
    assign ts_match      = ts_match_r;
    assign id_value      = id_value_r;
    assign ts_value      = ts_value_r;

endmodule
